// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: addresses, field positions, writable-bit masks,
// exception codes and the masked-merge helper used by every CSR write.
package csr_file_pkg;

    // CSR addresses
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // CRMD / PRMD fields
    localparam int CRMD_PLV_LSB = 0;
    localparam int CRMD_PLV_MSB = 1;
    localparam int CRMD_IE      = 2;
    localparam int CRMD_DA      = 3;
    localparam int PRMD_PPLV_LSB = 0;
    localparam int PRMD_PPLV_MSB = 1;
    localparam int PRMD_PIE      = 2;

    // ESTAT fields
    localparam int ESTAT_IS_SW_LSB = 0;
    localparam int ESTAT_IS_SW_MSB = 1;
    localparam int ESTAT_IS_HW_LSB = 2;
    localparam int ESTAT_IS_HW_MSB = 9;
    localparam int ESTAT_IS_TI     = 11;
    localparam int ESTAT_IS_IPI    = 12;
    localparam int ESTAT_ECODE_LSB = 16;
    localparam int ESTAT_ECODE_MSB = 21;
    localparam int ESTAT_ESUB_LSB  = 22;
    localparam int ESTAT_ESUB_MSB  = 30;

    // TCFG fields
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;

    // Bits that software may change through a CSR write
    localparam logic [31:0] CRMD_WRMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WRMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WRMASK   = 32'h0000_1FFF;
    localparam logic [31:0] ESTAT_WRMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WRMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] FULL_WRMASK   = 32'hFFFF_FFFF;

    // CRMD comes out of reset in direct-address mode, PLV0, interrupts off
    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

    // Exception codes
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Masked write: only bits both selected by wmask and writable change
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] wmask,
                                              input logic [31:0] writable);
        logic [31:0] sel;
        sel = wmask & writable;
        return (old_val & ~sel) | (wdata & sel);
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// Writeback-stage CSR port: WB (master) drives requests and commit events,
// the CSR file (slave) returns read data, redirect targets and interrupt flag.
interface csr_file_if;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  ecode;
    logic [2:0]  esubcode;
    logic [31:0] epc;
    logic [31:0] era;
    logic [31:0] eentry;
    logic [7:0]  hard_int_in;
    logic        ipi_int_in;
    logic        has_int;

    modport master (
        output csr_we, csr_num, csr_wmask, csr_wdata,
        output excp_flush, ertn_flush, ecode, esubcode, epc,
        output hard_int_in, ipi_int_in,
        input  csr_rdata, era, eentry, has_int
    );

    modport slave (
        input  csr_we, csr_num, csr_wmask, csr_wdata,
        input  excp_flush, ertn_flush, ecode, esubcode, epc,
        input  hard_int_in, ipi_int_in,
        output csr_rdata, era, eentry, has_int
    );
endinterface

// File: rtl/csr_timer.sv
// Stable timer: holds TCFG and the TVAL down-counter and flags the expiry
// cycle. The sticky TI bit lives in the parent CSR file.
module csr_timer
    import csr_file_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_tcfg_we,
    input  logic [31:0]        i_wdata,
    input  logic [31:0]        i_wmask,
    output logic [31:0]        o_tcfg,
    output logic [TIMER_W-1:0] o_tval,
    output logic               o_expire
);

    logic [31:0]        r_tcfg;
    logic [TIMER_W-1:0] r_tval;
    logic [31:0]        w_tcfg_new;
    logic [TIMER_W-1:0] w_load_val;
    logic [TIMER_W-1:0] w_reload_val;
    logic               w_expire;
    logic               w_halted;

    assign w_tcfg_new   = csr_merge(r_tcfg, i_wdata, i_wmask, FULL_WRMASK);
    assign w_load_val   = {w_tcfg_new[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
    assign w_reload_val = {r_tcfg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
    // All-ones is the parked state of a one-shot timer that already fired
    assign w_halted     = &r_tval;
    assign w_expire     = r_tcfg[TCFG_EN] && (r_tval == '0);

    // TCFG register: fully software writable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcfg <= '0;
        end else if (i_tcfg_we) begin
            r_tcfg <= w_tcfg_new;
        end
    end

    // TVAL counter: a TCFG write reloads it even in the expiry cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tval <= '0;
        end else if (i_tcfg_we) begin
            r_tval <= w_load_val;
        end else if (w_expire) begin
            r_tval <= r_tcfg[TCFG_PERIODIC] ? w_reload_val : '1;
        end else if (r_tcfg[TCFG_EN] && !w_halted) begin
            r_tval <= r_tval - TIMER_W'(1);
        end
    end

    assign o_tcfg   = r_tcfg;
    assign o_tval   = r_tval;
    assign o_expire = w_expire;

endmodule

// File: rtl/csr_file.sv
// LoongArch CSR file: responder of the WB CSR port. Handles masked CSR
// writes, exception/ertn commit updates, interrupt sampling and the timer.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] TID_INIT = 32'h0,
    parameter int          TIMER_W  = 32
) (
    input  logic       clk,
    input  logic       resetn,
    csr_file_if.slave  csr
);

    logic [31:0]        r_crmd;
    logic [31:0]        r_prmd;
    logic [31:0]        r_ecfg;
    logic [31:0]        r_estat;
    logic [31:0]        r_era;
    logic [31:0]        r_badv;
    logic [31:0]        r_eentry;
    logic [31:0]        r_save [4];
    logic [31:0]        r_tid;

    logic               w_wr;
    logic               w_ticlr;
    logic               w_tcfg_we;
    logic               w_timer_expire;
    logic [31:0]        w_tcfg;
    logic [TIMER_W-1:0] w_tval;
    logic [31:0]        w_rdata;

    // A committing exception or ertn swallows any CSR write in the same cycle
    assign w_wr      = csr.csr_we && !csr.excp_flush && !csr.ertn_flush;
    assign w_tcfg_we = w_wr && (csr.csr_num == CSR_TCFG);
    assign w_ticlr   = w_wr && (csr.csr_num == CSR_TICLR)
                       && csr.csr_wdata[0] && csr.csr_wmask[0];

    csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_tcfg_we (w_tcfg_we),
        .i_wdata   (csr.csr_wdata),
        .i_wmask   (csr.csr_wmask),
        .o_tcfg    (w_tcfg),
        .o_tval    (w_tval),
        .o_expire  (w_timer_expire)
    );

    // CRMD: exception drops to PLV0 with IE off, ertn restores from PRMD
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crmd <= CRMD_RESET;
        end else if (csr.excp_flush) begin
            r_crmd[CRMD_PLV_MSB:CRMD_PLV_LSB] <= 2'b00;
            r_crmd[CRMD_IE]                   <= 1'b0;
        end else if (csr.ertn_flush) begin
            r_crmd[CRMD_PLV_MSB:CRMD_PLV_LSB] <= r_prmd[PRMD_PPLV_MSB:PRMD_PPLV_LSB];
            r_crmd[CRMD_IE]                   <= r_prmd[PRMD_PIE];
        end else if (w_wr && csr.csr_num == CSR_CRMD) begin
            r_crmd <= csr_merge(r_crmd, csr.csr_wdata, csr.csr_wmask, CRMD_WRMASK);
        end
    end

    // PRMD: exception saves the current privilege level and IE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prmd <= '0;
        end else if (csr.excp_flush) begin
            r_prmd[PRMD_PPLV_MSB:PRMD_PPLV_LSB] <= r_crmd[CRMD_PLV_MSB:CRMD_PLV_LSB];
            r_prmd[PRMD_PIE]                    <= r_crmd[CRMD_IE];
        end else if (w_wr && csr.csr_num == CSR_PRMD) begin
            r_prmd <= csr_merge(r_prmd, csr.csr_wdata, csr.csr_wmask, PRMD_WRMASK);
        end
    end

    // ECFG: local interrupt enables
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ecfg <= '0;
        end else if (w_wr && csr.csr_num == CSR_ECFG) begin
            r_ecfg <= csr_merge(r_ecfg, csr.csr_wdata, csr.csr_wmask, ECFG_WRMASK);
        end
    end

    // ESTAT: sampled interrupt lines, sticky TI, exception cause, software IS
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_estat <= '0;
        end else begin
            r_estat[ESTAT_IS_HW_MSB:ESTAT_IS_HW_LSB] <= csr.hard_int_in;
            r_estat[ESTAT_IS_IPI]                    <= csr.ipi_int_in;
            // Expiry beats a TICLR landing in the same cycle
            if (w_timer_expire) begin
                r_estat[ESTAT_IS_TI] <= 1'b1;
            end else if (w_ticlr) begin
                r_estat[ESTAT_IS_TI] <= 1'b0;
            end
            if (csr.excp_flush) begin
                r_estat[ESTAT_ECODE_MSB:ESTAT_ECODE_LSB] <= csr.ecode;
                r_estat[ESTAT_ESUB_MSB:ESTAT_ESUB_LSB]   <= {6'b0, csr.esubcode};
            end else if (w_wr && csr.csr_num == CSR_ESTAT) begin
                r_estat[ESTAT_IS_SW_MSB:ESTAT_IS_SW_LSB] <=
                    csr.csr_wdata[ESTAT_IS_SW_MSB:ESTAT_IS_SW_LSB] &
                    csr.csr_wmask[ESTAT_IS_SW_MSB:ESTAT_IS_SW_LSB] |
                    r_estat[ESTAT_IS_SW_MSB:ESTAT_IS_SW_LSB] &
                    ~csr.csr_wmask[ESTAT_IS_SW_MSB:ESTAT_IS_SW_LSB];
            end
        end
    end

    // ERA: captures the faulting PC on exception
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_era <= '0;
        end else if (csr.excp_flush) begin
            r_era <= csr.epc;
        end else if (w_wr && csr.csr_num == CSR_ERA) begin
            r_era <= csr_merge(r_era, csr.csr_wdata, csr.csr_wmask, FULL_WRMASK);
        end
    end

    // BADV and TID: plain software-written registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_badv <= '0;
            r_tid  <= TID_INIT;
        end else if (w_wr) begin
            if (csr.csr_num == CSR_BADV) begin
                r_badv <= csr_merge(r_badv, csr.csr_wdata, csr.csr_wmask, FULL_WRMASK);
            end
            if (csr.csr_num == CSR_TID) begin
                r_tid <= csr_merge(r_tid, csr.csr_wdata, csr.csr_wmask, FULL_WRMASK);
            end
        end
    end

    // EENTRY: handler base, kept 64-byte aligned
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_eentry <= '0;
        end else if (w_wr && csr.csr_num == CSR_EENTRY) begin
            r_eentry <= csr_merge(r_eentry, csr.csr_wdata, csr.csr_wmask, EENTRY_WRMASK);
        end
    end

    // SAVE0-3: scratch registers, low two address bits pick the slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= '0;
            end
        end else if (w_wr && csr.csr_num[13:2] == CSR_SAVE0[13:2]) begin
            r_save[csr.csr_num[1:0]] <= csr_merge(r_save[csr.csr_num[1:0]],
                                                  csr.csr_wdata, csr.csr_wmask,
                                                  FULL_WRMASK);
        end
    end

    // Read mux: current register state, unimplemented addresses read zero
    always_comb begin
        w_rdata = '0;
        case (csr.csr_num)
            CSR_CRMD:   w_rdata = r_crmd;
            CSR_PRMD:   w_rdata = r_prmd;
            CSR_ECFG:   w_rdata = r_ecfg;
            CSR_ESTAT:  w_rdata = r_estat;
            CSR_ERA:    w_rdata = r_era;
            CSR_BADV:   w_rdata = r_badv;
            CSR_EENTRY: w_rdata = r_eentry;
            CSR_SAVE0:  w_rdata = r_save[0];
            CSR_SAVE1:  w_rdata = r_save[1];
            CSR_SAVE2:  w_rdata = r_save[2];
            CSR_SAVE3:  w_rdata = r_save[3];
            CSR_TID:    w_rdata = r_tid;
            CSR_TCFG:   w_rdata = w_tcfg;
            CSR_TVAL:   w_rdata = 32'(w_tval);
            default:    w_rdata = '0;
        endcase
    end

    assign csr.csr_rdata = w_rdata;
    assign csr.era       = r_era;
    assign csr.eentry    = r_eentry;
    assign csr.has_int   = r_crmd[CRMD_IE] && (|(r_estat[12:0] & r_ecfg[12:0]));

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations, then
// random traffic checked every cycle against a register-map model.
module tb_csr_file;

    localparam logic [31:0] TID_INIT = 32'h0;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    csr_file_if bus();

    csr_file #(
        .TID_INIT (TID_INIT),
        .TIMER_W  (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .csr    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: address -> value, and address -> writable bits
    bit [31:0] regs [int];
    bit [31:0] wmsk [int];
    bit [31:0] m_tval;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        regs.delete();
        foreach (wmsk[k]) regs[k] = 32'h0;
        regs[0]     = 32'h8;
        regs['h40]  = TID_INIT;
        m_tval      = 32'h0;
    endtask

    function automatic bit [31:0] m_read(input int a);
        if (a == 'h42) return m_tval;
        if (regs.exists(a)) return regs[a];
        return 32'h0;
    endfunction

    function automatic bit m_has_int();
        bit [31:0] c;
        bit [31:0] e;
        bit [31:0] f;
        c = regs[0];
        e = regs[5];
        f = regs[4];
        return c[2] & (|(e[12:0] & f[12:0]));
    endfunction

    // One clock of architectural behaviour, from the register-level rules
    task automatic model_step();
        bit [31:0] nxt [int];
        bit [31:0] cr;
        bit [31:0] pr;
        bit [31:0] tc;
        bit [31:0] es;
        bit [31:0] t;
        bit [31:0] m;
        int        a;
        bit        wr;
        bit        expire;
        bit        ticlr;
        nxt    = regs;
        a      = int'(bus.csr_num);
        wr     = bus.csr_we && !bus.excp_flush && !bus.ertn_flush;
        cr     = regs[0];
        pr     = regs[1];
        tc     = regs['h41];
        expire = tc[0] && (m_tval == 32'h0);
        ticlr  = wr && (a == 'h44) && bus.csr_wdata[0] && bus.csr_wmask[0];
        if (wr && wmsk.exists(a)) begin
            m      = bus.csr_wmask & wmsk[a];
            nxt[a] = (regs[a] & ~m) | (bus.csr_wdata & m);
        end
        if (bus.excp_flush) begin
            t = nxt[1]; t[2:0] = cr[2:0]; nxt[1] = t;
            t = nxt[0]; t[2:0] = 3'b000;  nxt[0] = t;
            nxt[6] = bus.epc;
        end else if (bus.ertn_flush) begin
            t = nxt[0]; t[2:0] = pr[2:0]; nxt[0] = t;
        end
        es = nxt[5];
        if (bus.excp_flush) begin
            es[21:16] = bus.ecode;
            es[30:22] = {6'b0, bus.esubcode};
        end
        es[9:2] = bus.hard_int_in;
        es[12]  = bus.ipi_int_in;
        if (expire)     es[11] = 1'b1;
        else if (ticlr) es[11] = 1'b0;
        nxt[5] = es;
        if (wr && a == 'h41) begin
            t      = nxt['h41];
            m_tval = {t[31:2], 2'b00};
        end else if (expire) begin
            m_tval = tc[1] ? {tc[31:2], 2'b00} : 32'hFFFF_FFFF;
        end else if (tc[0] && m_tval != 32'hFFFF_FFFF) begin
            m_tval = m_tval - 32'h1;
        end
        regs = nxt;
    endtask

    always @(posedge clk) if (resetn) model_step();
    always @(negedge resetn) model_reset();

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rdata",   bus.csr_rdata, m_read(int'(bus.csr_num)));
            cmp("era",     bus.era,       regs[6]);
            cmp("eentry",  bus.eentry,    regs['hC]);
            cmp("has_int", {31'b0, bus.has_int}, {31'b0, m_has_int()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.csr_we     = 1'b0;
        bus.excp_flush = 1'b0;
        bus.ertn_flush = 1'b0;
        bus.csr_wmask  = 32'h0;
        bus.csr_wdata  = 32'h0;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] d, input logic [31:0] mk);
        bus.csr_num   = num;
        bus.csr_wdata = d;
        bus.csr_wmask = mk;
        bus.csr_we    = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string nm);
        bus.csr_num = num;
        #1;
        cmp(nm, bus.csr_rdata, exp);
    endtask

    task automatic rd_bit(input logic [13:0] num, input int b, input logic exp, input string nm);
        logic [31:0] v;
        bus.csr_num = num;
        #1;
        v = bus.csr_rdata;
        cmp(nm, {31'b0, v[b]}, {31'b0, exp});
    endtask

    int addrs [17] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC, 'h30, 'h31, 'h32, 'h33,
                       'h40, 'h41, 'h42, 'h44, 'h2, 'h3FFF};

    initial begin
        logic [31:0] v;
        wmsk[0] = 32'h1FF;  wmsk[1] = 32'h7;  wmsk[4] = 32'h1FFF;  wmsk[5] = 32'h3;
        wmsk[6] = 32'hFFFF_FFFF;  wmsk[7] = 32'hFFFF_FFFF;  wmsk['hC] = 32'hFFFF_FFC0;
        wmsk['h30] = 32'hFFFF_FFFF;  wmsk['h31] = 32'hFFFF_FFFF;
        wmsk['h32] = 32'hFFFF_FFFF;  wmsk['h33] = 32'hFFFF_FFFF;
        wmsk['h40] = 32'hFFFF_FFFF;  wmsk['h41] = 32'hFFFF_FFFF;
        idle();
        bus.csr_num     = 14'h0;
        bus.ecode       = 6'h0;
        bus.esubcode    = 3'h0;
        bus.epc         = 32'h0;
        bus.hard_int_in = 8'h0;
        bus.ipi_int_in  = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        rd(14'h0, 32'h8, "rst_crmd");
        rd(14'h42, 32'h0, "rst_tval");
        cmp("rst_has_int", {31'b0, bus.has_int}, 32'h0);
        cmp("rst_era", bus.era, 32'h0);
        cmp("rst_eentry", bus.eentry, 32'h0);

        // EENTRY alignment
        wr(14'hC, 32'h1C00_807F, 32'hFFFF_FFFF);
        cmp("eentry_align", bus.eentry, 32'h1C00_8040);

        // Exception entry and ertn
        wr(14'h0, 32'h7, 32'hFFFF_FFFF);
        rd(14'h0, 32'h7, "crmd_wr");
        bus.excp_flush = 1'b1;
        bus.ecode      = 6'h0B;
        bus.epc        = 32'h1C00_0100;
        tick();
        idle();
        rd(14'h0, 32'h0, "excp_crmd");
        rd(14'h1, 32'h7, "excp_prmd");
        cmp("excp_era", bus.era, 32'h1C00_0100);
        bus.csr_num = 14'h5;
        #1;
        v = bus.csr_rdata;
        cmp("excp_ecode", {26'b0, v[21:16]}, 32'hB);
        bus.ertn_flush = 1'b1;
        tick();
        idle();
        rd(14'h0, 32'h7, "ertn_crmd");

        // Periodic timer, TI interrupt, TICLR
        wr(14'h4, 32'h800, 32'hFFFF_FFFF);
        wr(14'h41, 32'hB, 32'hFFFF_FFFF);
        rd(14'h42, 32'h8, "tval_load");
        for (int k = 7; k >= 0; k--) begin
            tick();
            rd(14'h42, 32'(k), "tval_count");
        end
        tick();
        rd(14'h42, 32'h8, "tval_reload");
        rd_bit(14'h5, 11, 1'b1, "ti_set");
        cmp("ti_has_int", {31'b0, bus.has_int}, 32'h1);
        wr(14'h44, 32'h1, 32'h1);
        rd_bit(14'h5, 11, 1'b0, "ti_clr");
        cmp("ticlr_has_int", {31'b0, bus.has_int}, 32'h0);
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);

        // One-shot timer halts at all-ones
        wr(14'h41, 32'h9, 32'hFFFF_FFFF);
        repeat (8) tick();
        rd(14'h42, 32'h0, "oneshot_zero");
        tick();
        rd(14'h42, 32'hFFFF_FFFF, "oneshot_ff");
        rd_bit(14'h5, 11, 1'b1, "oneshot_ti");
        repeat (3) tick();
        rd(14'h42, 32'hFFFF_FFFF, "oneshot_hold");
        wr(14'h44, 32'h1, 32'h1);
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);

        // Write blocked by exception; hardware interrupt latency
        wr(14'h30, 32'h1234, 32'hFFFF_FFFF);
        bus.csr_num    = 14'h30;
        bus.csr_wdata  = 32'hFFFF;
        bus.csr_wmask  = 32'hFFFF_FFFF;
        bus.csr_we     = 1'b1;
        bus.excp_flush = 1'b1;
        tick();
        idle();
        rd(14'h30, 32'h1234, "save0_excp");
        bus.ertn_flush = 1'b1;
        tick();
        idle();
        wr(14'h4, 32'h4, 32'hFFFF_FFFF);
        bus.hard_int_in = 8'h01;
        bus.csr_num     = 14'h0;
        #1;
        cmp("hwi_pre", {31'b0, bus.has_int}, 32'h0);
        tick();
        cmp("hwi_post", {31'b0, bus.has_int}, 32'h1);
        bus.hard_int_in = 8'h00;
        tick();

        // Random traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                resetn = 1'b0;
                tick();
                tick();
                resetn = 1'b1;
            end
            bus.csr_num    = 14'(addrs[$urandom_range(0, 16)]);
            bus.csr_we     = ($urandom_range(0, 1) == 1);
            bus.excp_flush = ($urandom_range(0, 19) == 0);
            bus.ertn_flush = ($urandom_range(0, 19) == 0);
            bus.csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            bus.csr_wdata  = $urandom;
            if (bus.csr_num == 14'h41)
                bus.csr_wdata = (32'($urandom_range(0, 4)) << 2) | ($urandom & 32'h3);
            bus.ecode    = 6'($urandom);
            bus.esubcode = 3'($urandom);
            bus.epc      = $urandom;
            if ($urandom_range(0, 7) == 0) bus.hard_int_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.ipi_int_in  = 1'($urandom);
            tick();
        end
        idle();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
